// File: rtl/pio_out_blink.sv
// pio_out_blink: Avalon-MM output PIO with SET/CLEAR/TOGGLE write
// registers and a hardware blink engine that inverts masked bits.
//
// Optional build macro: PIO_OUT_BLINK_IRQ_EN
//   defined   -> IRQ_MASK register at address 7; irq = wrap_flag & IRQ_MASK[0]
//   undefined -> address 7 reads 0 and ignores writes; irq tied to 0
//
// Register map (word addresses):
//   0 DATA (RW)  1 SET (WO)  2 CLEAR (WO)  3 TOGGLE (WO)
//   4 BLINK_MASK (RW)  5 PERIOD (RW)  6 STATUS {phase, wrap_flag(W1C)}
//   7 IRQ_MASK (RW bit0, optional)
//
// Bus handshake: zero-wait-state slave. A write is accepted on every rising
// clk edge where wr = chipselect & ~write_n; there is no waitrequest. readdata
// is a pure combinational function of address and the registers, valid in the
// same cycle, and reading never changes state.
module pio_out_blink #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_SET      = 3'd1;
  localparam logic [2:0] A_CLEAR    = 3'd2;
  localparam logic [2:0] A_TOGGLE   = 3'd3;
  localparam logic [2:0] A_MASK     = 3'd4;
  localparam logic [2:0] A_PERIOD   = 3'd5;
  localparam logic [2:0] A_STATUS   = 3'd6;
  localparam logic [2:0] A_IRQ_MASK = 3'd7;

  logic                wr;
  logic [WIDTH-1:0]    wd_w;
  logic [PERIOD_W-1:0] wd_p;

  logic [WIDTH-1:0]    data_q,   data_d;
  logic [WIDTH-1:0]    mask_q,   mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q,    cnt_d;
  logic                phase_q,  phase_d;
  logic                wrap_q,   wrap_d;
  logic                wrap_evt;
  logic                wrap_clr;

  // Upper writedata bits beyond WIDTH/PERIOD_W are intentionally ignored.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr   = chipselect & ~write_n;
  assign wd_w = writedata[WIDTH-1:0];
  assign wd_p = writedata[PERIOD_W-1:0];

  // Next-state: blink engine first, then bus writes override where they apply.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    wrap_evt = 1'b0;
    wrap_clr = 1'b0;

    // PERIOD == 0 is the idle mode: counter and phase parked at zero.
    if (period_q != '0) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - PERIOD_W'(1);
      end else begin
        cnt_d    = period_q;
        phase_d  = ~phase_q;
        wrap_evt = 1'b1;
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end

    if (wr) begin
      case (address)
        A_DATA:   data_d = wd_w;
        A_SET:    data_d = data_q | wd_w;
        A_CLEAR:  data_d = data_q & ~wd_w;
        A_TOGGLE: data_d = data_q ^ wd_w;
        A_MASK:   mask_d = wd_w;
        A_PERIOD: begin
          // A PERIOD write restarts the engine and beats any reload due now.
          period_d = wd_p;
          cnt_d    = wd_p;
          phase_d  = 1'b0;
          wrap_evt = 1'b0;
        end
        A_STATUS: wrap_clr = writedata[0];
        default:  ;
      endcase
    end

    // A wrap on the same edge as a W1C wins: the flag stays set.
    if (wrap_evt) begin
      wrap_d = 1'b1;
    end else if (wrap_clr) begin
      wrap_d = 1'b0;
    end else begin
      wrap_d = wrap_q;
    end
  end

  // Register bank and blink engine state, asynchronously reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out_port = data_q ^ (mask_q & {WIDTH{phase_q}});

`ifdef PIO_OUT_BLINK_IRQ_EN
  logic irq_mask_q, irq_mask_d;

  // IRQ mask next-state: only bit0 of address 7 is storage.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr && (address == A_IRQ_MASK)) begin
      irq_mask_d = writedata[0];
    end
  end

  // IRQ mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
    end
  end

  assign irq = wrap_q & irq_mask_q;
`else
  logic irq_mask_q;
  assign irq_mask_q = 1'b0;
  assign irq        = 1'b0;
`endif

  // Read mux: selected register zero-extended; write-only addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:     readdata[WIDTH-1:0]    = data_q;
      A_MASK:     readdata[WIDTH-1:0]    = mask_q;
      A_PERIOD:   readdata[PERIOD_W-1:0] = period_q;
      A_STATUS:   readdata[1:0]          = {phase_q, wrap_q};
      A_IRQ_MASK: readdata[0]            = irq_mask_q;
      default:    readdata               = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_out_blink.sv
// tb_pio_out_blink: directed bench for pio_out_blink (WIDTH=8,
// RESET_VALUE=8'hA5). Expected out_port values are queued when stimulus is
// applied and popped after the corresponding clock edge.
module tb_pio_out_blink;

  localparam int              W     = 8;
  localparam logic [W-1:0]    RST_V = 8'hA5;
`ifdef PIO_OUT_BLINK_IRQ_EN
  localparam logic            IRQ_EN = 1'b1;
`else
  localparam logic            IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;
  logic          irq;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   rd;

  pio_out_blink #(
    .WIDTH       (W),
    .RESET_VALUE (RST_V),
    .PERIOD_W    (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the next expected out_port value and compare.
  task automatic check_out(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {24'h0, out_port}, e);
    end
  endtask

  // Driver: one write cycle; returns 1 time unit after the write edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [2:0] a,
                          input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back({24'h0, RST_V});
    check_out("rst_out");
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], rd);
      check_eq($sformatf("rst_rd%0d", a), rd, (a == 0) ? {24'h0, RST_V} : 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // DATA / SET / CLEAR / TOGGLE; upper writedata bits must be ignored.
    exp_q.push_back(32'h0F); bus_write(3'd0, 32'h1234_560F); check_out("data_wr");
    exp_q.push_back(32'h3F); bus_write(3'd1, 32'hFFFF_FF30); check_out("set_wr");
    exp_q.push_back(32'h3E); bus_write(3'd2, 32'h0000_0001); check_out("clr_wr");
    exp_q.push_back(32'hC1); bus_write(3'd3, 32'h0000_00FF); check_out("tgl_wr");
    check_rd("data_rd", 3'd0, 32'hC1);
    check_rd("set_rd0", 3'd1, 32'h0);
    check_rd("tgl_rd0", 3'd3, 32'h0);

    // Blink at PERIOD=3: phase toggles every 4 edges after the write edge.
    exp_q.push_back(32'h00); bus_write(3'd0, 32'h00); check_out("data0");
    exp_q.push_back(32'h00); bus_write(3'd4, 32'h81); check_out("mask_wr");
    check_rd("mask_rd", 3'd4, 32'h81);
    exp_q.push_back(32'h00); bus_write(3'd5, 32'd3);  check_out("per3_wr");
    check_rd("per_rd", 3'd5, 32'd3);
    for (int k = 1; k <= 13; k++) exp_q.push_back(((k / 4) % 2) ? 32'h81 : 32'h00);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check_out($sformatf("blink3_k%0d", k));
    end
    check_rd("status_run", 3'd6, 32'h3);

    // PERIOD=0 while phase=1 stops the engine at once.
    exp_q.push_back(32'h00); bus_write(3'd5, 32'd0); check_out("per0_wr");
    check_rd("status_stop", 3'd6, 32'h1);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'h00);
      tick();
      check_out($sformatf("idle_k%0d", k));
    end

    // PERIOD=1: toggles every 2 clocks.
    exp_q.push_back(32'h00); bus_write(3'd5, 32'd1); check_out("per1_wr");
    for (int k = 1; k <= 8; k++) exp_q.push_back(((k / 2) % 2) ? 32'h81 : 32'h00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_out($sformatf("blink1_k%0d", k));
    end

    // Stop, clear wrap flag, then exercise the interrupt path with PERIOD=2.
    bus_write(3'd5, 32'd0);
    bus_write(3'd6, 32'h1);
    check_rd("status_w1c", 3'd6, 32'h0);
    check_eq("irq_clr", {31'h0, irq}, 32'h0);
    bus_write(3'd7, 32'h1);
    check_rd("irqmask_rd", 3'd7, {31'h0, IRQ_EN});
    bus_write(3'd5, 32'd2);                                  // k=0
    tick(); check_eq("irq_k1", {31'h0, irq}, 32'h0);        // k=1
    tick(); check_eq("irq_k2", {31'h0, irq}, 32'h0);        // k=2
    tick(); check_eq("irq_k3", {31'h0, irq}, {31'h0, IRQ_EN});
    check_rd("status_k3", 3'd6, 32'h3);
    bus_write(3'd6, 32'h1);                                  // k=4, no wrap
    check_eq("irq_w1c", {31'h0, irq}, 32'h0);
    check_rd("status_k4", 3'd6, 32'h2);
    tick();                                                  // k=5
    check_rd("status_k5", 3'd6, 32'h2);
    bus_write(3'd6, 32'h1);                                  // k=6, wrap edge
    check_rd("status_k6", 3'd6, 32'h1);
    check_eq("irq_k6", {31'h0, irq}, {31'h0, IRQ_EN});

    // Reset mid-blink with phase=1.
    tick(); tick(); tick();                                  // k=9, phase=1
    exp_q.push_back(32'h81);
    check_out("preblink_rst");
    #1 reset_n = 1'b0;
    #1;
    exp_q.push_back({24'h0, RST_V});
    check_out("async_rst");
    check_eq("rst_irq2", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back({24'h0, RST_V});
      tick();
      check_out($sformatf("post_rst_k%0d", k));
    end
    check_rd("post_rst_per", 3'd5, 32'h0);
    check_rd("post_rst_stat", 3'd6, 32'h0);
    check_rd("post_rst_mask", 3'd4, 32'h0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
